// File: rtl/inf_send_if.sv
// Handshake and line bundle between an inf_send transmitter and whatever
// drives it. The controller side uses the master view; the transmitter
// uses the slave view.
interface inf_send_if;
   logic       start;       // request one frame, honoured only when idle
   logic       repeat_req;  // level, checked at the end of every gap
   logic [7:0] addr;        // address byte, captured with start
   logic [7:0] cmd;         // command byte, captured with start
   logic       busy;        // transmitter is not idle
   logic       done;        // one-cycle pulse on return to idle
   logic       inf_out;     // carrier-modulated LED drive
   logic       inf_env;     // unmodulated envelope for loopback

   modport master (
      output start, repeat_req, addr, cmd,
      input  busy, done, inf_out, inf_env
   );

   modport slave (
      input  start, repeat_req, addr, cmd,
      output busy, done, inf_out, inf_env
   );
endinterface

// File: rtl/inf_send.sv
// NEC-format infrared transmitter. A start request sends one frame:
// leader, addr, ~addr, cmd, ~cmd (LSB first) and a stop mark. While
// repeat_req is held, a repeat code follows every frame period.
// inf_env is the mark/space envelope; inf_out is that envelope gated by a
// carrier that always begins each mark in its high phase.
module inf_send #(
   parameter int unsigned T_LEAD_MARK  = 450000,
   parameter int unsigned T_LEAD_SPACE = 225000,
   parameter int unsigned T_REP_SPACE  = 112500,
   parameter int unsigned T_BIT_MARK   = 28000,
   parameter int unsigned T_ZERO_SPACE = 28000,
   parameter int unsigned T_ONE_SPACE  = 84500,
   parameter int unsigned T_FRAME      = 5500000,
   parameter int unsigned CARR_DIV     = 1316,
   parameter int unsigned CARR_HIGH    = 439
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   inf_send_if.slave   bus
);

   function automatic int unsigned imax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned P_MAX = imax(imax(imax(T_LEAD_MARK, T_LEAD_SPACE),
                                             imax(T_REP_SPACE, T_BIT_MARK)),
                                        imax(imax(T_ZERO_SPACE, T_ONE_SPACE),
                                             imax(T_FRAME, CARR_DIV)));
   localparam int CW  = $clog2(P_MAX + 1);
   localparam int CAW = (CARR_DIV > 1) ? $clog2(CARR_DIV) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE,
      S_STOP_MARK, S_GAP, S_REP_MARK, S_REP_SPACE, S_REP_STOP
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_dur;      // cycles spent in the current state
   logic [CW-1:0]   r_frm;      // cycles since the last leader / repeat start
   logic [31:0]     r_shreg;    // remaining payload, next bit in [0]
   logic [5:0]      r_bit_cnt;  // payload bits already sent
   logic [CAW-1:0]  r_carr;     // carrier phase
   logic            r_busy;
   logic            r_done;
   logic            r_env;
   logic            r_out;

   logic [CW-1:0]   w_dur_last;
   logic            w_dur_end;
   logic            w_frm_end;
   logic            w_enter;
   logic            w_accept;
   logic            w_shift;
   logic [CAW-1:0]  w_carr_nxt;
   logic            w_env_nxt;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic            w_out_nxt;

   // Last count value of each timed state; a bit space is long for a 1.
   function automatic logic [CW-1:0] dur_last(input state_t s, input logic one);
      case (s)
         S_LEAD_MARK, S_REP_MARK:             return CW'(T_LEAD_MARK - 1);
         S_LEAD_SPACE:                        return CW'(T_LEAD_SPACE - 1);
         S_REP_SPACE:                         return CW'(T_REP_SPACE - 1);
         S_BIT_MARK, S_STOP_MARK, S_REP_STOP: return CW'(T_BIT_MARK - 1);
         S_BIT_SPACE:                         return one ? CW'(T_ONE_SPACE - 1)
                                                         : CW'(T_ZERO_SPACE - 1);
         default:                             return '0;
      endcase
   endfunction

   assign w_dur_last = dur_last(r_state, r_shreg[0]);
   assign w_dur_end  = (r_dur == w_dur_last);
   assign w_frm_end  = (r_frm == CW'(T_FRAME - 1));
   assign w_enter    = (w_state_nxt != r_state);
   assign w_accept   = (r_state == S_IDLE) && bus.start;
   assign w_shift    = (r_state == S_BIT_SPACE) && w_dur_end;

   // State register; reset returns to idle from anywhere in a frame.
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update together from the values present before the edge.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state decode: each timed state ends on its last count, the gap on the frame boundary.
   // NOTE: the hold-state default is assigned first so no path leaves
   // w_state_nxt unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:       if (bus.start) w_state_nxt = S_LEAD_MARK;
         S_LEAD_MARK:  if (w_dur_end) w_state_nxt = S_LEAD_SPACE;
         S_LEAD_SPACE: if (w_dur_end) w_state_nxt = S_BIT_MARK;
         S_BIT_MARK:   if (w_dur_end) w_state_nxt = S_BIT_SPACE;
         S_BIT_SPACE:  if (w_dur_end) w_state_nxt = (r_bit_cnt == 6'd31) ? S_STOP_MARK
                                                                         : S_BIT_MARK;
         S_STOP_MARK:  if (w_dur_end) w_state_nxt = S_GAP;
         S_GAP:        if (w_frm_end) w_state_nxt = bus.repeat_req ? S_REP_MARK : S_IDLE;
         S_REP_MARK:   if (w_dur_end) w_state_nxt = S_REP_SPACE;
         S_REP_SPACE:  if (w_dur_end) w_state_nxt = S_REP_STOP;
         S_REP_STOP:   if (w_dur_end) w_state_nxt = S_GAP;
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so the registered outputs line up with the state.
   always_comb begin
      w_env_nxt  = (w_state_nxt == S_LEAD_MARK) || (w_state_nxt == S_BIT_MARK) ||
                   (w_state_nxt == S_STOP_MARK) || (w_state_nxt == S_REP_MARK) ||
                   (w_state_nxt == S_REP_STOP);
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (r_state == S_GAP) && (w_state_nxt == S_IDLE);
      w_carr_nxt = (w_enter || r_carr == CAW'(CARR_DIV - 1)) ? '0 : r_carr + 1'b1;
      w_out_nxt  = w_env_nxt && (32'(w_carr_nxt) < CARR_HIGH);
   end

   // Timing counters, payload shift register and carrier phase.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_dur     <= '0;
         r_frm     <= '0;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_carr    <= '0;
      end else begin
         r_dur  <= (w_enter || r_state == S_IDLE) ? '0 : r_dur + 1'b1;
         r_carr <= w_carr_nxt;
         if (w_enter && (w_state_nxt == S_LEAD_MARK || w_state_nxt == S_REP_MARK))
            r_frm <= '0;
         else if (r_state != S_IDLE)
            r_frm <= r_frm + 1'b1;
         if (w_accept) begin
            r_shreg   <= {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
            r_bit_cnt <= '0;
         end else if (w_shift) begin
            r_shreg   <= {1'b0, r_shreg[31:1]};
            r_bit_cnt <= r_bit_cnt + 6'd1;
         end
      end
   end

   // Registered line and status outputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_env  <= 1'b0;
         r_out  <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_env  <= w_env_nxt;
         r_out  <= w_out_nxt;
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.inf_env = r_env;
   assign bus.inf_out = r_out;

endmodule

// File: tb/tb_inf_send.sv
// Bench for inf_send with timings scaled down by 1000. Expected mark/space
// segments are queued when a frame is requested; a monitor measures the
// envelope, pops and compares each finished segment and checks the carrier
// pattern inside it. Scenario tasks check reset, done timing and queue drain.
module tb_inf_send;

   localparam int LM = 450, LS = 225, RS = 112, BM = 28, ZS = 28, OS = 84;
   localparam int FR = 5500, CD = 8, CH = 3;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   inf_send_if bus();

   inf_send #(
      .T_LEAD_MARK(LM), .T_LEAD_SPACE(LS), .T_REP_SPACE(RS), .T_BIT_MARK(BM),
      .T_ZERO_SPACE(ZS), .T_ONE_SPACE(OS), .T_FRAME(FR), .CARR_DIV(CD), .CARR_HIGH(CH)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct { logic mark; int len; } seg_t;
   seg_t sb[$];

   function automatic void push_seg(input logic m, input int l);
      seg_t s;
      s.mark = m;
      s.len  = l;
      sb.push_back(s);
   endfunction

   // Queue one data frame; returns its length up to the end of the stop mark.
   function automatic int push_frame(input logic [7:0] a, input logic [7:0] c);
      logic [31:0] d;
      int          total;
      d = {~c, c, ~a, a};
      push_seg(1'b1, LM);
      push_seg(1'b0, LS);
      total = LM + LS;
      for (int i = 0; i < 32; i++) begin
         push_seg(1'b1, BM);
         push_seg(1'b0, d[i] ? OS : ZS);
         total += BM + (d[i] ? OS : ZS);
      end
      push_seg(1'b1, BM);
      return total + BM;
   endfunction

   function automatic void push_repeat();
      push_seg(1'b1, LM);
      push_seg(1'b0, RS);
      push_seg(1'b1, BM);
   endfunction

   // Envelope monitor: measure each run and compare when it ends.
   logic m_env   = 1'b0;
   int   m_run   = 0;
   int   m_bad   = 0;
   bit   m_valid = 1'b0;
   always @(negedge sys_clk) begin
      seg_t e;
      logic exp_out;
      if (bus.inf_env !== m_env) begin
         if (m_env === 1'b1 || m_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL segment: unexpected %s of %0d cycles", m_env ? "mark" : "space", m_run);
            end else begin
               e = sb.pop_front();
               if (e.mark !== m_env || e.len !== m_run) begin
                  n_err++;
                  $display("FAIL segment: got %s len %0d, expected %s len %0d",
                           m_env ? "mark" : "space", m_run, e.mark ? "mark" : "space", e.len);
               end
            end
            n_cmp++;
            if (m_bad !== 0) begin
               n_err++;
               $display("FAIL carrier: %0d wrong inf_out cycles in %s of %0d, expected 0",
                        m_bad, m_env ? "mark" : "space", m_run);
            end
         end
         m_env   = bus.inf_env;
         m_run   = 0;
         m_bad   = 0;
         m_valid = 1'b1;
      end
      m_run++;
      exp_out = (m_env === 1'b1) ? (((m_run - 1) % CD) < CH) : 1'b0;
      if (bus.inf_out !== exp_out) m_bad++;
      if (bus.busy !== 1'b1 && bus.inf_env === 1'b0) m_valid = 1'b0;
   end

   task automatic send_start(input logic [7:0] a, input logic [7:0] c, output int e);
      @(negedge sys_clk);
      bus.addr  = a;
      bus.cmd   = c;
      bus.start = 1'b1;
      e = cyc + 1;
   endtask

   task automatic wait_done(input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (bus.done === 1'b1) begin
            at = cyc;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);
         n_cmp++;
         if ({bus.busy, bus.done, bus.inf_out, bus.inf_env} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: outputs %b, expected 0000",
                     {bus.busy, bus.done, bus.inf_out, bus.inf_env});
         end
         bus.start      = ~bus.start;
         bus.repeat_req = ~bus.repeat_req;
         bus.addr       = 8'($urandom);
         bus.cmd        = 8'($urandom);
      end
      sys_rst        = 1'b0;
      bus.start      = 1'b0;
      bus.repeat_req = 1'b0;
      repeat (3) @(negedge sys_clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.inf_out, bus.inf_env} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_release: outputs %b, expected 0000",
                  {bus.busy, bus.done, bus.inf_out, bus.inf_env});
      end
   endtask

   task automatic test_frame();
      int e, at, len;
      bit ok;
      len = push_frame(8'h00, 8'h45);
      send_start(8'h00, 8'h45, e);
      @(negedge sys_clk);
      bus.start = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.inf_env !== 1'b1 || bus.inf_out !== 1'b1) begin
         n_err++;
         $display("FAIL frame_first: busy/env/out %b%b%b, expected 111",
                  bus.busy, bus.inf_env, bus.inf_out);
      end
      wait_done(FR + 100, at, ok);
      n_cmp++;
      if (!ok || at !== e + FR) begin
         n_err++;
         $display("FAIL frame_done: done at %0d (seen %0d), expected %0d (len %0d)", at, ok, e + FR, len);
      end
      @(negedge sys_clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL frame_idle: done/busy %b%b, expected 00", bus.done, bus.busy);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL frame_drain: %0d segments left, expected 0", sb.size());
      end
   endtask

   task automatic test_repeat();
      int e, at, len;
      bit ok;
      bus.repeat_req = 1'b1;
      len = push_frame(8'hA5, 8'h3C);
      push_seg(1'b0, FR - len);
      push_repeat();
      push_seg(1'b0, FR - (LM + RS + BM));
      push_repeat();
      send_start(8'hA5, 8'h3C, e);
      @(negedge sys_clk);
      bus.start = 1'b0;
      while (cyc < e + 2 * FR + 10) @(negedge sys_clk);
      bus.repeat_req = 1'b0;
      wait_done(FR + 100, at, ok);
      n_cmp++;
      if (!ok || at !== e + 3 * FR) begin
         n_err++;
         $display("FAIL repeat_done: done at %0d (seen %0d), expected %0d", at, ok, e + 3 * FR);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL repeat_drain: %0d segments left, expected 0", sb.size());
      end
   endtask

   task automatic test_ignore_start();
      int e, at, len;
      bit ok;
      logic [7:0] a, c;
      a = 8'($urandom);
      c = 8'($urandom);
      len = push_frame(a, c);
      send_start(a, c, e);
      @(negedge sys_clk);
      bus.start = 1'b0;
      bus.addr  = ~a;
      bus.cmd   = ~c;
      while (cyc < e + 1500) @(negedge sys_clk);
      bus.start = 1'b1;
      @(negedge sys_clk);
      bus.start = 1'b0;
      wait_done(FR, at, ok);
      n_cmp++;
      if (!ok || at !== e + FR) begin
         n_err++;
         $display("FAIL ignore_done: done at %0d (seen %0d), expected %0d (len %0d)", at, ok, e + FR, len);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL ignore_drain: %0d segments left, expected 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      int e1, e2, at, len;
      bit ok;
      len = push_frame(8'h12, 8'h34);
      send_start(8'h12, 8'h34, e1);
      @(negedge sys_clk);
      bus.start = 1'b0;
      wait_done(FR + 100, at, ok);
      n_cmp++;
      if (!ok || at !== e1 + FR) begin
         n_err++;
         $display("FAIL b2b_done1: done at %0d (seen %0d), expected %0d", at, ok, e1 + FR);
      end
      len = push_frame(8'hC6, 8'h0F);
      bus.addr  = 8'hC6;
      bus.cmd   = 8'h0F;
      bus.start = 1'b1;
      e2 = cyc + 1;
      @(negedge sys_clk);
      bus.start = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.inf_env !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_accept: busy/env %b%b, expected 11", bus.busy, bus.inf_env);
      end
      wait_done(FR + 100, at, ok);
      n_cmp++;
      if (!ok || at !== e2 + FR) begin
         n_err++;
         $display("FAIL b2b_done2: done at %0d (seen %0d), expected %0d (len %0d)", at, ok, e2 + FR, len);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL b2b_drain: %0d segments left, expected 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int e, at, len;
      bit ok;
      len = push_frame(8'h00, 8'h45);
      send_start(8'h00, 8'h45, e);
      @(negedge sys_clk);
      bus.start = 1'b0;
      // first payload bit is a 0: its space covers e+703 .. e+730
      while (cyc < e + 710) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.done, bus.inf_out, bus.inf_env} !== 4'b0000) begin
         n_err++;
         $display("FAIL midrst_idle: outputs %b, expected 0000",
                  {bus.busy, bus.done, bus.inf_out, bus.inf_env});
      end
      sb.delete();
      repeat (4) @(negedge sys_clk);
      len = push_frame(8'h5A, 8'hC3);
      send_start(8'h5A, 8'hC3, e);
      @(negedge sys_clk);
      bus.start = 1'b0;
      wait_done(FR + 100, at, ok);
      n_cmp++;
      if (!ok || at !== e + FR) begin
         n_err++;
         $display("FAIL midrst_done: done at %0d (seen %0d), expected %0d (len %0d)", at, ok, e + FR, len);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL midrst_drain: %0d segments left, expected 0", sb.size());
      end
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.repeat_req = 1'b0;
      bus.addr       = 8'h00;
      bus.cmd        = 8'h00;
      test_reset();
      test_frame();
      test_repeat();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      repeat (5) @(negedge sys_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish within 90000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
